// File: rtl/diferential_pkg.sv
// -----------------------------------------------------------------------------
// diferential_pkg
// Shared definitions for the serial configuration loader that feeds the
// mux-cell fabric: default fabric geometry, the frame sync pattern, the
// loader state encoding and a row-major cell index helper.
// -----------------------------------------------------------------------------
package diferential_pkg;

    localparam int DEF_ROWS     = 3;
    localparam int DEF_COLS     = 3;
    localparam int DEF_CFG_BITS = 4;

    // Frame sync nibble, sent MSB-first ahead of the payload.
    localparam logic [DEF_CFG_BITS-1:0] DEF_SYNC = 4'b1010;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Row-major position of cell (r,c); (0,0) is the first cell on the wire
    // and occupies the lowest config slot.
    function automatic int cell_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/diferential_nibble_xor.sv
// -----------------------------------------------------------------------------
// diferential_nibble_xor
// Running XOR accumulator over W-bit nibbles arriving one bit per enabled
// cycle, MSB-first.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator and the partial nibble
//   en         : shift bit_in into the nibble register this cycle
//   bit_in     : serial data bit
//   done       : this enabled bit completes a nibble; fold it into acc
//   nib_next   : the nibble including the current bit_in (combinational)
//   acc        : XOR of all completed nibbles since the last clear
// -----------------------------------------------------------------------------
module diferential_nibble_xor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic         bit_in,
    input  logic         done,
    output logic [W-1:0] nib_next,
    output logic [W-1:0] acc
);

    logic [W-1:0] nib;

    assign nib_next = {nib[W-2:0], bit_in};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            nib <= '0;
            acc <= '0;
        end else if (en) begin
            nib <= nib_next;
            if (done) begin
                acc <= acc ^ nib_next;
            end
        end
    end

endmodule

// File: rtl/diferential_cfg_loader.sv
// -----------------------------------------------------------------------------
// diferential_cfg_loader
// Serial configuration loader for the mux-cell fabric. Hunts for a sync
// nibble, collects one config nibble per cell into a shadow register, then
// compares a trailing checksum nibble against the XOR of all payload nibbles.
// The fabric-facing bus only ever shows a fully checked frame.
//   clk, reset : clock, synchronous active-high reset
//   cfg_bit    : serial config data (MSB-first per nibble, cells row-major)
//   cfg_valid  : qualifies cfg_bit; idle cycles change nothing
//   cfg_out    : committed config, cell (r,c) at [(r*COLS+c)*CFG_BITS +: CFG_BITS]
//   cfg_loaded : one-cycle pulse on a successful commit
//   cfg_err    : one-cycle pulse on checksum mismatch
//   cfg_ready  : sticky, set by the first commit after reset
//   busy       : high while in LOAD or CHECK
// -----------------------------------------------------------------------------
module diferential_cfg_loader
    import diferential_pkg::*;
#(
    parameter int                  ROWS     = DEF_ROWS,
    parameter int                  COLS     = DEF_COLS,
    parameter int                  CFG_BITS = DEF_CFG_BITS,
    parameter logic [CFG_BITS-1:0] SYNC     = DEF_SYNC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_bit,
    input  logic                          cfg_valid,
    output logic [ROWS*COLS*CFG_BITS-1:0] cfg_out,
    output logic                          cfg_loaded,
    output logic                          cfg_err,
    output logic                          cfg_ready,
    output logic                          busy
);

    localparam int TOT = ROWS * COLS * CFG_BITS;
    localparam int CW  = $clog2(TOT + 1);

    state_t               state;
    state_t               state_next;
    logic [CFG_BITS-1:0]  window;
    logic [CFG_BITS-1:0]  win_next;
    logic [CW-1:0]        cnt;
    logic [TOT-1:0]       shadow;
    logic [CFG_BITS-1:0]  nib_next;
    logic [CFG_BITS-1:0]  acc;
    logic                 sync_hit;
    logic                 last_payload;
    logic                 last_check;
    logic                 nib_done;

    assign win_next     = {window[CFG_BITS-2:0], cfg_bit};
    assign sync_hit     = (state == HUNT) && cfg_valid && (win_next == SYNC);
    assign last_payload = (cnt == CW'(TOT - 1));
    assign last_check   = (cnt == CW'(CFG_BITS - 1));
    assign nib_done     = (state == LOAD) && ((int'(cnt) % CFG_BITS) == CFG_BITS - 1);
    assign busy         = (state != HUNT);

    // The checksum nibble is shifted through the same nibble register as the
    // payload, so at the final check bit nib_next holds the received checksum
    // while acc (not folded during CHECK) holds the expected one.
    diferential_nibble_xor #(
        .W (CFG_BITS)
    ) u_xor (
        .clk      (clk),
        .reset    (reset),
        .clear    (sync_hit),
        .en       (cfg_valid && (state != HUNT)),
        .bit_in   (cfg_bit),
        .done     (nib_done),
        .nib_next (nib_next),
        .acc      (acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (cfg_valid) begin
            case (state)
                HUNT:    if (win_next == SYNC) state_next = LOAD;
                LOAD:    if (last_payload)     state_next = CHECK;
                CHECK:   if (last_check)       state_next = HUNT;
                default:                       state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window     <= '0;
            cnt        <= '0;
            shadow     <= '0;
            cfg_out    <= '0;
            cfg_loaded <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            cfg_loaded <= 1'b0;
            cfg_err    <= 1'b0;
            if (cfg_valid) begin
                case (state)
                    HUNT: begin
                        window <= (win_next == SYNC) ? '0 : win_next;
                        cnt    <= '0;
                    end
                    LOAD: begin
                        // Completed nibbles enter at the top and move down, so
                        // the first cell on the wire ends in the lowest slot.
                        if (nib_done) begin
                            shadow <= {nib_next, shadow[TOT-1:CFG_BITS]};
                        end
                        cnt <= last_payload ? '0 : cnt + 1'b1;
                    end
                    CHECK: begin
                        if (last_check) begin
                            cnt    <= '0;
                            window <= '0;
                            if (nib_next == acc) begin
                                cfg_out    <= shadow;
                                cfg_loaded <= 1'b1;
                                cfg_ready  <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
